// File: rtl/qa_drv_prim_pkg.sv
// Shared types and the address-to-bucket hash for the QA driver write-order gate.
package qa_drv_prim_pkg;

    localparam int ADDR_WIDTH = 42;
    localparam int N_BUCKETS  = 64;
    localparam int N_TAGS     = 32;

    localparam int IDX_W    = $clog2(N_BUCKETS);
    localparam int TAG_W    = $clog2(N_TAGS);
    localparam int CNT_W    = TAG_W + 1;
    localparam int N_SLICES = (ADDR_WIDTH + IDX_W - 1) / IDX_W;

    typedef logic [ADDR_WIDTH-1:0] t_addr;
    typedef logic [IDX_W-1:0]      t_filter_idx;
    typedef logic [TAG_W-1:0]      t_tag;
    typedef logic [CNT_W-1:0]      t_count;

    typedef struct packed {
        logic        valid;
        t_addr       addr;
        logic        is_write;
        t_filter_idx bucket;
    } t_held_req;

    // XOR-fold of the address; the top slice is zero-padded by the widening cast.
    function automatic t_filter_idx qa_drv_prim_hash_addr(input t_addr addr);
        logic [N_SLICES*IDX_W-1:0] padded;
        t_filter_idx               h;
        padded = (N_SLICES*IDX_W)'(addr);
        h      = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            h = h ^ padded[i*IDX_W +: IDX_W];
        end
        return h;
    endfunction

endpackage

// File: rtl/qa_drv_prim_write_order_gate_if.sv
// Request, issue, response and filter-client signals of the write-order gate.
interface qa_drv_prim_write_order_gate_if;
    import qa_drv_prim_pkg::*;

    logic        req_valid;
    logic        req_ready;
    t_addr       req_addr;
    logic        req_is_write;

    logic        out_valid;
    logic        out_ready;
    t_addr       out_addr;
    logic        out_is_write;
    t_tag        out_tag;

    logic        rsp_valid;
    t_tag        rsp_tag;

    t_filter_idx filt_test_req;
    logic        filt_test_isZero;
    logic        filt_test_notFull;
    t_filter_idx filt_insert;
    logic        filt_insert_en;
    t_filter_idx filt_remove;
    logic        filt_remove_en;

    t_count      n_outstanding;
    logic        err_bad_rsp;

    modport slave (
        input  req_valid, req_addr, req_is_write, out_ready, rsp_valid, rsp_tag,
               filt_test_isZero, filt_test_notFull,
        output req_ready, out_valid, out_addr, out_is_write, out_tag,
               filt_test_req, filt_insert, filt_insert_en, filt_remove, filt_remove_en,
               n_outstanding, err_bad_rsp
    );

    modport master (
        output req_valid, req_addr, req_is_write, out_ready, rsp_valid, rsp_tag,
               filt_test_isZero, filt_test_notFull,
        input  req_ready, out_valid, out_addr, out_is_write, out_tag,
               filt_test_req, filt_insert, filt_insert_en, filt_remove, filt_remove_en,
               n_outstanding, err_bad_rsp
    );

endinterface

// File: rtl/qa_drv_prim_tag_alloc.sv
// Outstanding-tag tracker: busy vector, lowest-free encoder, per-tag bucket table, popcount.
module qa_drv_prim_tag_alloc
    import qa_drv_prim_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc_en,
    input  t_filter_idx alloc_bucket,
    input  logic        rsp_valid,
    input  t_tag        rsp_tag,
    output logic        tag_free,
    output t_tag        free_tag,
    output logic        rsp_hit,
    output t_filter_idx rsp_bucket,
    output t_count      n_outstanding
);

    logic [N_TAGS-1:0] busy_q, busy_d;
    t_count            n_outstanding_q, n_outstanding_d;
    t_filter_idx       tag_bucket_q [N_TAGS];

    // Registered busy only: a tag retired this cycle is not offered again until next cycle.
    always_comb begin
        tag_free = 1'b0;
        free_tag = '0;
        for (int i = N_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                tag_free = 1'b1;
                free_tag = t_tag'(i);
            end
        end
    end

    assign rsp_hit    = rsp_valid & busy_q[rsp_tag];
    assign rsp_bucket = rsp_hit ? tag_bucket_q[rsp_tag] : '0;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (alloc_en) busy_d[free_tag] = 1'b1;
        if (rsp_hit)  busy_d[rsp_tag]  = 1'b0;
        n_outstanding_d = '0;
        for (int i = 0; i < N_TAGS; i++) begin
            n_outstanding_d = n_outstanding_d + t_count'(busy_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q          <= '0;
            n_outstanding_q <= '0;
        end else begin
            busy_q          <= busy_d;
            n_outstanding_q <= n_outstanding_d;
        end
    end

    // NOTE: the bucket table is not reset; an entry is only read while its busy bit is set.
    always_ff @(posedge clk) begin
        if (alloc_en) tag_bucket_q[free_tag] <= alloc_bucket;
    end

    assign n_outstanding = n_outstanding_q;

endmodule

// File: rtl/qa_drv_prim_write_order_gate.sv
// Issue gate: holds one request and releases it only when its filter bucket has nothing in flight.
module qa_drv_prim_write_order_gate
    import qa_drv_prim_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    qa_drv_prim_write_order_gate_if.slave bus
);

    t_held_req   held_q, held_d;
    logic        err_bad_rsp_q, err_bad_rsp_d;

    logic        tag_free;
    t_tag        free_tag;
    logic        rsp_hit;
    t_filter_idx rsp_bucket;
    t_count      n_outstanding;

    logic        out_valid;
    logic        issue;
    logic        req_ready;
    logic        accept;

    // out_valid never looks at out_ready, so downstream may wait on it without a loop.
    assign out_valid = held_q.valid & bus.filt_test_isZero & bus.filt_test_notFull & tag_free;
    assign issue     = out_valid & bus.out_ready;
    assign req_ready = ~held_q.valid | issue;
    assign accept    = bus.req_valid & req_ready;

    qa_drv_prim_tag_alloc u_tag_alloc (
        .clk           (clk),
        .reset         (reset),
        .alloc_en      (issue),
        .alloc_bucket  (held_q.bucket),
        .rsp_valid     (bus.rsp_valid),
        .rsp_tag       (bus.rsp_tag),
        .tag_free      (tag_free),
        .free_tag      (free_tag),
        .rsp_hit       (rsp_hit),
        .rsp_bucket    (rsp_bucket),
        .n_outstanding (n_outstanding)
    );

    always_comb begin
        held_d        = held_q;
        err_bad_rsp_d = err_bad_rsp_q | (bus.rsp_valid & ~rsp_hit);
        if (accept) begin
            held_d.valid    = 1'b1;
            held_d.addr     = bus.req_addr;
            held_d.is_write = bus.req_is_write;
            held_d.bucket   = qa_drv_prim_hash_addr(bus.req_addr);
        end else if (issue) begin
            held_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q        <= '0;
            err_bad_rsp_q <= 1'b0;
        end else begin
            held_q        <= held_d;
            err_bad_rsp_q <= err_bad_rsp_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_addr       = held_q.addr;
    assign bus.out_is_write   = held_q.is_write;
    assign bus.out_tag        = free_tag;
    assign bus.filt_test_req  = held_q.bucket;
    assign bus.filt_insert    = held_q.bucket;
    assign bus.filt_insert_en = issue;
    assign bus.filt_remove    = rsp_bucket;
    assign bus.filt_remove_en = rsp_hit;
    assign bus.n_outstanding  = n_outstanding;
    assign bus.err_bad_rsp    = err_bad_rsp_q;

endmodule

// File: tb/tb_qa_drv_prim_write_order_gate.sv
// Directed bench for the write-order gate with a bench-side counting filter and reference model.
module tb_qa_drv_prim_write_order_gate;
    import qa_drv_prim_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic force_zero;
    always #5 clk = ~clk;

    qa_drv_prim_write_order_gate_if bus ();

    qa_drv_prim_write_order_gate dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Parent-side counting filter; force_zero lets the bench report an empty bucket on demand.
    logic [3:0] filt_cnt [N_BUCKETS];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BUCKETS; i++) filt_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < N_BUCKETS; i++) begin
                filt_cnt[i] <= filt_cnt[i]
                    + 4'((bus.filt_insert_en && int'(bus.filt_insert) == i) ? 1 : 0)
                    - 4'((bus.filt_remove_en && int'(bus.filt_remove) == i) ? 1 : 0);
            end
        end
    end
    assign bus.filt_test_isZero  = force_zero | (filt_cnt[bus.filt_test_req] == 4'd0);
    assign bus.filt_test_notFull = (filt_cnt[bus.filt_test_req] != 4'hF);

    // Reference model: bucket of an address is the XOR of address bit b into bucket bit b mod 6.
    function automatic int model_hash(input logic [ADDR_WIDTH-1:0] a);
        int h = 0;
        for (int b = 0; b < ADDR_WIDTH; b++) if (a[b]) h = h ^ (1 << (b % IDX_W));
        return h;
    endfunction

    bit                  m_held;
    logic [ADDR_WIDTH-1:0] m_addr;
    bit                  m_w;
    bit                  m_busy    [N_TAGS];
    int                  m_tbucket [N_TAGS];
    int                  m_cnt     [N_BUCKETS];
    bit                  m_err;

    always @(negedge clk) begin
        int  hb, ft, nbusy, rt;
        bit  any_free, ev, iss, hit, er;
        if (reset) begin
            m_held = 0; m_err = 0;
            for (int i = 0; i < N_TAGS; i++) m_busy[i] = 0;
            for (int i = 0; i < N_BUCKETS; i++) m_cnt[i] = 0;
            check("rst_req_ready", bus.req_ready, 1);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_insert_en", bus.filt_insert_en, 0);
            check("rst_remove_en", bus.filt_remove_en, 0);
            check("rst_n_out", bus.n_outstanding, 0);
            check("rst_err", bus.err_bad_rsp, 0);
            check("rst_out_tag", bus.out_tag, 0);
        end else begin
            hb = model_hash(m_addr);
            any_free = 0; ft = 0; nbusy = 0;
            for (int i = N_TAGS - 1; i >= 0; i--) if (!m_busy[i]) begin any_free = 1; ft = i; end
            for (int i = 0; i < N_TAGS; i++) nbusy += m_busy[i] ? 1 : 0;
            ev  = m_held && (force_zero || m_cnt[hb] == 0) && m_cnt[hb] < 15 && any_free;
            iss = ev && bus.out_ready;
            rt  = int'(bus.rsp_tag);
            hit = bus.rsp_valid && m_busy[rt];
            er  = !m_held || iss;

            check("out_valid", bus.out_valid, ev);
            check("req_ready", bus.req_ready, er);
            check("insert_en", bus.filt_insert_en, iss);
            check("remove_en", bus.filt_remove_en, hit);
            check("n_outstanding", bus.n_outstanding, nbusy);
            check("err_bad_rsp", bus.err_bad_rsp, m_err);
            if (any_free) check("out_tag", bus.out_tag, ft);
            if (m_held) begin
                check("out_addr", bus.out_addr, m_addr);
                check("out_is_write", bus.out_is_write, m_w);
                check("test_req", bus.filt_test_req, hb);
            end
            if (iss) check("insert_bucket", bus.filt_insert, hb);
            if (hit) check("remove_bucket", bus.filt_remove, m_tbucket[rt]);

            if (hit) begin m_busy[rt] = 0; m_cnt[m_tbucket[rt]]--; end
            if (iss) begin m_busy[ft] = 1; m_tbucket[ft] = hb; m_cnt[hb]++; end
            if (bus.rsp_valid && !hit) m_err = 1;
            if (bus.req_valid && er) begin m_held = 1; m_addr = bus.req_addr; m_w = bus.req_is_write; end
            else if (iss) m_held = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after the edge that accepted it.
    task automatic send_req(input logic [ADDR_WIDTH-1:0] a, input logic w);
        bit acc;
        int n;
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_is_write = w;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.req_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        if (!acc) check("accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; force_zero = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_is_write = 1'b0;
        bus.out_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_tag = '0;
        repeat (3) tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;

        // First write to 0x40 issues next cycle on tag 0, bucket 1.
        send_req(42'h40, 1'b1);
        @(negedge clk);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_tag", bus.out_tag, 0);
        check("t1_insert_en", bus.filt_insert_en, 1);
        check("t1_insert", bus.filt_insert, 1);
        tick();

        // 0x1000 also hashes to bucket 1: stall until tag 0 retires.
        send_req(42'h1000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_valid", bus.out_valid, 0);
            check("t2_stall_ready", bus.req_ready, 0);
            tick();
        end
        bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd0;
        @(negedge clk);
        check("t2_remove_en", bus.filt_remove_en, 1);
        check("t2_remove", bus.filt_remove, 1);
        check("t2_rsp_cycle_valid", bus.out_valid, 0);
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("t2_release_valid", bus.out_valid, 1);
        check("t2_release_tag", bus.out_tag, 0);
        tick();
        bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd0;
        tick();
        bus.rsp_valid = 1'b0;

        // Fill every tag with distinct buckets, then one more request waits for a tag.
        for (int i = 0; i < N_TAGS; i++) send_req(ADDR_WIDTH'(i), i[0]);
        send_req(42'd32, 1'b1);
        @(negedge clk);
        check("t3_full_valid", bus.out_valid, 0);
        check("t3_full_count", bus.n_outstanding, 32);
        tick();
        bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd5;
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("t3_reuse_valid", bus.out_valid, 1);
        check("t3_reuse_tag", bus.out_tag, 5);
        tick();

        // Issue on bucket 3 while tag 3 (bucket 3) retires in the same cycle.
        bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd7;
        tick();
        bus.rsp_valid = 1'b0;
        send_req(42'd3, 1'b1);
        @(negedge clk);
        check("t4_blocked", bus.out_valid, 0);
        tick();
        force_zero = 1'b1; bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd3;
        @(negedge clk);
        check("t4_insert_en", bus.filt_insert_en, 1);
        check("t4_insert", bus.filt_insert, 3);
        check("t4_remove_en", bus.filt_remove_en, 1);
        check("t4_remove", bus.filt_remove, 3);
        check("t4_tag", bus.out_tag, 7);
        tick();
        force_zero = 1'b0; bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("t4_count_unchanged", filt_cnt[3], 1);

        // Response for a free tag flags an error and removes nothing.
        tick();
        bus.rsp_valid = 1'b1; bus.rsp_tag = 5'd3;
        @(negedge clk);
        check("t5_remove_en", bus.filt_remove_en, 0);
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("t5_err", bus.err_bad_rsp, 1);
        repeat (3) tick();
        @(negedge clk);
        check("t5_err_sticky", bus.err_bad_rsp, 1);

        // Asynchronous reset mid-stream, then five outstanding and reset again.
        tick();
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send_req(ADDR_WIDTH'(40 + i), 1'b0);
        tick();
        @(negedge clk);
        check("t6_five_out", bus.n_outstanding, 5);
        tick();
        #2 reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", bus.req_ready, 1);
        check("t6_rst_count", bus.n_outstanding, 0);
        tick();
        reset = 1'b0;
        send_req(42'd50, 1'b1);
        @(negedge clk);
        check("t6_after_valid", bus.out_valid, 1);
        check("t6_after_tag", bus.out_tag, 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
